// File: rtl/noc_pkg.sv
// Shared NoC definitions for the virtual-channel input buffer:
// default widths and depths, plus the VC identifier type.
package noc_pkg;

  localparam int FLIT_W_DEF   = 8;
  localparam int NUM_VC       = 2;
  localparam int VC_DEPTH_DEF = 4;

  typedef enum logic {
    VC0 = 1'b0,
    VC1 = 1'b1
  } vc_id_t;

endpackage : noc_pkg

// File: rtl/vc_input_buffer_if.sv
// Link-side and switch-side signals of the VC input buffer.
// The slave modport is the buffer; the master modport is the link/switch driver.
interface vc_input_buffer_if
  import noc_pkg::*;
#(
  parameter int FLIT_W = FLIT_W_DEF
);

  logic [FLIT_W-1:0] in_data;
  vc_id_t            in_vc;
  logic              in_valid;
  logic              out_ready;
  logic [NUM_VC-1:0] in_ready;
  logic [FLIT_W-1:0] vc0_data;
  logic [FLIT_W-1:0] vc1_data;
  logic              vc0_valid;
  logic              vc1_valid;
  logic [NUM_VC-1:0] credit_out;
  logic              overflow_err;

  modport slave (
    input  in_data, in_vc, in_valid, out_ready,
    output in_ready, vc0_data, vc1_data, vc0_valid, vc1_valid,
           credit_out, overflow_err
  );

  modport master (
    output in_data, in_vc, in_valid, out_ready,
    input  in_ready, vc0_data, vc1_data, vc0_valid, vc1_valid,
           credit_out, overflow_err
  );

endinterface : vc_input_buffer_if

// File: rtl/vc_fifo.sv
// Single-VC circular FIFO: registered pointers and count, head always visible.
// A push on full or a pop on empty is ignored.
module vc_fifo
  import noc_pkg::*;
#(
  parameter int FLIT_W = FLIT_W_DEF,
  parameter int DEPTH  = VC_DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [FLIT_W-1:0] push_data,
  input  logic              pop,
  output logic [FLIT_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; only the pointers/count define validity,
  // which keeps the array a plain RAM with no reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule : vc_fifo

// File: rtl/vc_input_buffer.sv
// Two-VC router input buffer: per-VC FIFOs, fixed VC0-over-VC1 pop priority,
// registered credit return and a sticky overflow flag.
module vc_input_buffer
  import noc_pkg::*;
#(
  parameter int FLIT_W   = FLIT_W_DEF,
  parameter int VC_DEPTH = VC_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  vc_input_buffer_if.slave   bus
);

  localparam int CNT_W = $clog2(VC_DEPTH) + 1;

  logic [NUM_VC-1:0] push;
  logic [NUM_VC-1:0] pop;
  logic [NUM_VC-1:0] full;
  logic [NUM_VC-1:0] empty;
  logic [CNT_W-1:0]  count0;
  logic [CNT_W-1:0]  count1;
  logic              drop;
  logic [NUM_VC-1:0] credit_q;
  logic              overflow_q;

  // Full comes from registered count, so a same-cycle pop never frees a slot
  // for the incoming flit.
  assign push[0] = bus.in_valid && (bus.in_vc == VC0) && !full[0];
  assign push[1] = bus.in_valid && (bus.in_vc == VC1) && !full[1];
  assign drop    = bus.in_valid && full[bus.in_vc];

  assign bus.vc0_valid = !empty[0] && bus.out_ready;
  assign bus.vc1_valid = !empty[1] && bus.out_ready;

  // The switch serves VC0 first; VC1 only moves when VC0 has nothing to offer.
  assign pop[0] = bus.vc0_valid;
  assign pop[1] = bus.vc1_valid && !bus.vc0_valid;

  assign bus.in_ready     = ~full;
  assign bus.credit_out   = credit_q;
  assign bus.overflow_err = overflow_q;

  vc_fifo #(.FLIT_W(FLIT_W), .DEPTH(VC_DEPTH)) u_fifo_vc0 (
    .clk       (clk),
    .reset     (reset),
    .push      (push[0]),
    .push_data (bus.in_data),
    .pop       (pop[0]),
    .head      (bus.vc0_data),
    .full      (full[0]),
    .empty     (empty[0]),
    .count     (count0)
  );

  vc_fifo #(.FLIT_W(FLIT_W), .DEPTH(VC_DEPTH)) u_fifo_vc1 (
    .clk       (clk),
    .reset     (reset),
    .push      (push[1]),
    .push_data (bus.in_data),
    .pop       (pop[1]),
    .head      (bus.vc1_data),
    .full      (full[1]),
    .empty     (empty[1]),
    .count     (count1)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      credit_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      credit_q   <= pop;
      overflow_q <= overflow_q | drop;
    end
  end

endmodule : vc_input_buffer

// File: tb/tb_vc_input_buffer.sv
// Directed self-checking bench for vc_input_buffer with hand-computed
// expectations for priority, full/overflow, wrap and reset behaviour.
module tb_vc_input_buffer;
  import noc_pkg::*;

  localparam int FLIT_W   = 8;
  localparam int VC_DEPTH = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  vc_input_buffer_if #(.FLIT_W(FLIT_W)) bus ();

  vc_input_buffer #(.FLIT_W(FLIT_W), .VC_DEPTH(VC_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input vc_id_t vc, input logic [FLIT_W-1:0] data);
    bus.in_valid = valid;
    bus.in_vc    = vc;
    bus.in_data  = data;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b0, VC0, 8'h00);
    step();
    step();
    reset = 1'b0;

    // Reset state
    bus.out_ready = 1'b1;
    #1;
    check("rst_vc0_valid", 32'(bus.vc0_valid), 32'd0);
    check("rst_vc1_valid", 32'(bus.vc1_valid), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'h3);
    check("rst_credit",    32'(bus.credit_out), 32'h0);
    check("rst_overflow",  32'(bus.overflow_err), 32'd0);

    // Single flit on VC0: visible the cycle after the write, credit one later
    drive(1'b1, VC0, 8'h11);
    step();
    drive(1'b0, VC0, 8'h00);
    #1;
    check("t1_vc0_valid", 32'(bus.vc0_valid), 32'd1);
    check("t1_vc0_data",  32'(bus.vc0_data),  32'h11);
    check("t1_credit0",   32'(bus.credit_out), 32'h0);
    step();
    check("t1_credit1",   32'(bus.credit_out), 32'h1);
    check("t1_vc0_empty", 32'(bus.vc0_valid), 32'd0);
    step();
    check("t1_credit2",   32'(bus.credit_out), 32'h0);

    // Priority: load VC1=A0 then VC0=B0 while held, then release
    bus.out_ready = 1'b0;
    drive(1'b1, VC1, 8'hA0);
    step();
    drive(1'b1, VC0, 8'hB0);
    step();
    drive(1'b0, VC0, 8'h00);
    #1;
    check("t2_hold_vc0_valid", 32'(bus.vc0_valid), 32'd0);
    check("t2_hold_vc1_valid", 32'(bus.vc1_valid), 32'd0);
    bus.out_ready = 1'b1;
    #1;
    check("t2_vc0_valid", 32'(bus.vc0_valid), 32'd1);
    check("t2_vc0_data",  32'(bus.vc0_data),  32'hB0);
    check("t2_vc1_valid", 32'(bus.vc1_valid), 32'd1);
    check("t2_vc1_data",  32'(bus.vc1_data),  32'hA0);
    step();
    check("t2_credit_vc0",    32'(bus.credit_out), 32'h1);
    check("t2_vc0_done",      32'(bus.vc0_valid), 32'd0);
    check("t2_vc1_still",     32'(bus.vc1_valid), 32'd1);
    check("t2_vc1_data_still",32'(bus.vc1_data),  32'hA0);
    step();
    check("t2_credit_vc1", 32'(bus.credit_out), 32'h2);
    check("t2_vc1_done",   32'(bus.vc1_valid), 32'd0);
    step();

    // Fill VC0 while held, overflow on the 5th flit, then drain in order
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, VC0, 8'(i));
      step();
    end
    check("t3_in_ready_full", 32'(bus.in_ready), 32'h2);
    check("t3_no_ovf_yet",    32'(bus.overflow_err), 32'd0);
    drive(1'b1, VC0, 8'h05);
    step();
    drive(1'b0, VC0, 8'h00);
    check("t3_overflow",      32'(bus.overflow_err), 32'd1);
    check("t3_in_ready_held", 32'(bus.in_ready), 32'h2);
    bus.out_ready = 1'b1;
    #1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("t3_drain_valid%0d", i), 32'(bus.vc0_valid), 32'd1);
      check($sformatf("t3_drain_data%0d", i),  32'(bus.vc0_data),  32'(i));
      step();
    end
    check("t3_drained",       32'(bus.vc0_valid), 32'd0);
    check("t3_in_ready_back", 32'(bus.in_ready), 32'h3);
    check("t3_ovf_sticky",    32'(bus.overflow_err), 32'd1);

    // Full VC0 with a same-cycle push and pop: push rejected, count drops to 3
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, VC0, 8'(8'h21 + i));
      step();
    end
    bus.out_ready = 1'b1;
    drive(1'b1, VC0, 8'h25);
    step();
    drive(1'b0, VC0, 8'h00);
    check("t4_overflow",   32'(bus.overflow_err), 32'd1);
    check("t4_not_full",   32'(bus.in_ready), 32'h3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t4_drain_data%0d", i), 32'(bus.vc0_data), 32'(8'h22 + i));
      step();
    end
    check("t4_empty_after3", 32'(bus.vc0_valid), 32'd0);

    // Streaming VC1: push and pop together each cycle across pointer wrap
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, VC1, 8'(8'h10 + i));
      step();
      check($sformatf("t5_vc1_valid%0d", i), 32'(bus.vc1_valid), 32'd1);
      check($sformatf("t5_vc1_data%0d", i),  32'(bus.vc1_data),  32'(8'h10 + i));
      if (i > 0) check($sformatf("t5_credit%0d", i), 32'(bus.credit_out), 32'h2);
    end
    drive(1'b0, VC0, 8'h00);
    step();
    check("t5_vc1_empty",   32'(bus.vc1_valid), 32'd0);
    check("t5_no_overflow", 32'(bus.overflow_err), 32'd0);

    // Reset with both FIFOs partly full, overflow set, and a flit presented
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, VC0, 8'(8'h40 + i));
      step();
    end
    drive(1'b1, VC1, 8'h50);
    step();
    check("t6_pre_overflow", 32'(bus.overflow_err), 32'd1);
    drive(1'b1, VC1, 8'h51);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b0, VC0, 8'h00);
    bus.out_ready = 1'b1;
    #1;
    check("t6_vc0_valid", 32'(bus.vc0_valid), 32'd0);
    check("t6_vc1_valid", 32'(bus.vc1_valid), 32'd0);
    check("t6_in_ready",  32'(bus.in_ready), 32'h3);
    check("t6_credit",    32'(bus.credit_out), 32'h0);
    check("t6_overflow",  32'(bus.overflow_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_vc_input_buffer
